// File: rtl/uart_rx_periph.sv
// 8N1 UART receiver with a small receive FIFO behind a memory-mapped register chunk.
// Define UART_RX_IRQ_EN to generate a registered RX interrupt; otherwise o_IRQ is tied low.
module uart_rx_periph #(
    parameter int ADDR_WIDTH          = 16,
    parameter int ADDR_BITS_PER_CHUCK = 6,
    parameter int ADDR_BLOCK          = 2,
    parameter int CLKS_PER_BIT        = 868,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_UART_RX,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    output logic [31:0]           o_RD,
    input  logic                  i_WE,
    input  logic [3:0]            i_ByteEn,
    input  logic [31:0]           i_WD,
    output logic                  o_IRQ
);

    localparam int OW   = ADDR_BITS_PER_CHUCK;
    localparam int BW   = ADDR_WIDTH - ADDR_BITS_PER_CHUCK;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NW   = PW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    localparam logic [BW-1:0] BLOCK_ID   = BW'(ADDR_BLOCK);
    localparam logic [OW-1:0] OFF_DATA   = OW'(0);
    localparam logic [OW-1:0] OFF_STATUS = OW'(1);
    localparam logic [OW-1:0] OFF_CTRL   = OW'(2);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_FULL   = CW'(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_State;
    logic            r_RxMeta;
    logic            r_RxSync;
    logic [1:0]      r_SyncValid;
    logic            r_Armed;
    logic [CW-1:0]   r_ClkCnt;
    logic [2:0]      r_BitIdx;
    logic [7:0]      r_Shift;
    logic            r_PushValid;
    logic [7:0]      r_PushData;
    logic            r_FrameSet;

    logic [7:0]      r_Mem [FIFO_DEPTH];
    logic [PW-1:0]   r_WrPtr;
    logic [PW-1:0]   r_RdPtr;
    logic [NW-1:0]   r_Count;
    logic            r_Overrun;
    logic            r_FrameErr;

    logic            w_Sel;
    logic [OW-1:0]   w_Off;
    logic            w_NotEmpty;
    logic            w_Full;
    logic            w_Pop;
    logic            w_Clr;
    logic            w_DoPush;
    logic            w_OverSet;
    logic [7:0]      w_Head;
    logic [7:0]      w_Count8;
    logic            w_unused;

    assign w_Sel      = (i_Addr[ADDR_WIDTH-1:ADDR_BITS_PER_CHUCK] == BLOCK_ID);
    assign w_Off      = i_Addr[OW-1:0];
    assign w_NotEmpty = (r_Count != '0);
    assign w_Full     = (r_Count == NW'(FIFO_DEPTH));
    assign w_Pop      = w_Sel & i_WE & i_ByteEn[0] & (w_Off == OFF_DATA) & w_NotEmpty;
    assign w_Clr      = w_Sel & i_WE & i_ByteEn[0] & (w_Off == OFF_CTRL);
    assign w_DoPush   = r_PushValid & (~w_Full | w_Pop);
    assign w_OverSet  = r_PushValid & w_Full & ~w_Pop;
    assign w_Head     = w_NotEmpty ? r_Mem[r_RdPtr] : 8'h00;
    assign w_Count8   = 8'(r_Count);
    assign w_unused   = &{1'b0, i_WD[31:4], i_WD[1:0], i_ByteEn[3:1]};

    // r_SyncValid marks when the synchronizer holds real line samples rather than its reset value.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_RxMeta    <= 1'b1;
            r_RxSync    <= 1'b1;
            r_SyncValid <= 2'b00;
        end else begin
            r_RxMeta    <= i_UART_RX;
            r_RxSync    <= r_RxMeta;
            r_SyncValid <= {r_SyncValid[0], 1'b1};
        end
    end

    // r_Armed gates start detection until the line is seen idle after reset or a framing error.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State     <= S_IDLE;
            r_Armed     <= 1'b0;
            r_ClkCnt    <= '0;
            r_BitIdx    <= '0;
            r_Shift     <= '0;
            r_PushValid <= 1'b0;
            r_PushData  <= '0;
            r_FrameSet  <= 1'b0;
        end else begin
            r_PushValid <= 1'b0;
            r_FrameSet  <= 1'b0;
            if (r_SyncValid[1] && r_RxSync)
                r_Armed <= 1'b1;
            case (r_State)
                S_IDLE: begin
                    if (r_Armed && !r_RxSync) begin
                        r_ClkCnt <= CNT_HALF;
                        r_State  <= S_START;
                    end
                end
                S_START: begin
                    if (r_ClkCnt == CW'(1)) begin
                        if (!r_RxSync) begin
                            r_ClkCnt <= CNT_FULL;
                            r_BitIdx <= '0;
                            r_State  <= S_DATA;
                        end else begin
                            r_State  <= S_IDLE;
                        end
                    end else begin
                        r_ClkCnt <= r_ClkCnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_ClkCnt == CW'(1)) begin
                        r_Shift  <= {r_RxSync, r_Shift[7:1]};
                        r_ClkCnt <= CNT_FULL;
                        if (r_BitIdx == 3'd7)
                            r_State <= S_STOP;
                        else
                            r_BitIdx <= r_BitIdx + 3'd1;
                    end else begin
                        r_ClkCnt <= r_ClkCnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_ClkCnt == CW'(1)) begin
                        if (r_RxSync) begin
                            r_PushValid <= 1'b1;
                            r_PushData  <= r_Shift;
                        end else begin
                            r_FrameSet  <= 1'b1;
                            r_Armed     <= 1'b0;
                        end
                        r_State <= S_IDLE;
                    end else begin
                        r_ClkCnt <= r_ClkCnt - CW'(1);
                    end
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_DoPush)
            r_Mem[r_WrPtr] <= r_PushData;
    end

    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_WrPtr    <= '0;
            r_RdPtr    <= '0;
            r_Count    <= '0;
            r_Overrun  <= 1'b0;
            r_FrameErr <= 1'b0;
        end else begin
            if (w_DoPush)
                r_WrPtr <= r_WrPtr + PW'(1);
            if (w_Pop)
                r_RdPtr <= r_RdPtr + PW'(1);
            case ({w_DoPush, w_Pop})
                2'b10:   r_Count <= r_Count + NW'(1);
                2'b01:   r_Count <= r_Count - NW'(1);
                default: r_Count <= r_Count;
            endcase
            r_Overrun  <= w_OverSet  | (r_Overrun  & ~(w_Clr & i_WD[2]));
            r_FrameErr <= r_FrameSet | (r_FrameErr & ~(w_Clr & i_WD[3]));
        end
    end

    always_comb begin
        o_RD = '0;
        if (w_Sel) begin
            case (w_Off)
                OFF_DATA:   o_RD = {24'b0, w_Head};
                OFF_STATUS: o_RD = {16'b0, w_Count8, 4'b0, r_FrameErr, r_Overrun, w_Full, w_NotEmpty};
                default:    o_RD = '0;
            endcase
        end
    end

`ifdef UART_RX_IRQ_EN
    logic r_Irq;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_Irq <= 1'b0;
        else
            r_Irq <= w_NotEmpty | r_Overrun | r_FrameErr;
    end

    assign o_IRQ = r_Irq;
`else
    assign o_IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: frames, overflow, framing error, glitch, push+pop, reset, decode.
// Expects the IRQ to follow not_empty/overrun/frame_err only when UART_RX_IRQ_EN is defined.
module tb_uart_rx_periph;

    localparam int CPB = 4;
    localparam logic [15:0] A_DATA   = 16'h0080;
    localparam logic [15:0] A_STATUS = 16'h0081;
    localparam logic [15:0] A_CTRL   = 16'h0082;
    localparam logic [15:0] A_UNUSED = 16'h0083;
`ifdef UART_RX_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    logic        i_Clk;
    logic        i_Rst;
    logic        i_UART_RX;
    logic [15:0] i_Addr;
    logic [31:0] o_RD;
    logic        i_WE;
    logic [3:0]  i_ByteEn;
    logic [31:0] i_WD;
    logic        o_IRQ;

    int total;
    int bad;

    uart_rx_periph #(
        .ADDR_WIDTH(16),
        .ADDR_BITS_PER_CHUCK(6),
        .ADDR_BLOCK(2),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_UART_RX(i_UART_RX),
        .i_Addr(i_Addr),
        .o_RD(o_RD),
        .i_WE(i_WE),
        .i_ByteEn(i_ByteEn),
        .i_WD(i_WD),
        .o_IRQ(o_IRQ)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle bus write, launched just after a falling edge.
    task automatic applyStimulus(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
        i_Addr   = addr;
        i_ByteEn = be;
        i_WD     = wd;
        i_WE     = 1'b1;
        @(negedge i_Clk);
        i_WE     = 1'b0;
        i_ByteEn = 4'h0;
        i_WD     = 32'h0;
    endtask

    task automatic expectReg(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        i_Addr = addr;
        #1;
        checkOutput(tag, o_RD, exp);
    endtask

    task automatic sendBit(input logic b);
        i_UART_RX = b;
        repeat (CPB) @(negedge i_Clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(stopBit);
    endtask

    task automatic idle(input int n);
        i_UART_RX = 1'b1;
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic popExpect(input string tag, input logic [7:0] d);
        expectReg(tag, A_DATA, {24'h0, d});
        applyStimulus(A_DATA, 4'h1, 32'h0);
    endtask

    initial begin
        logic [7:0] partial;
        total     = 0;
        bad       = 0;
        i_Rst     = 1'b1;
        i_UART_RX = 1'b1;
        i_Addr    = 16'h0;
        i_WE      = 1'b0;
        i_ByteEn  = 4'h0;
        i_WD      = 32'h0;
        repeat (3) @(negedge i_Clk);
        expectReg("reset_status", A_STATUS, 32'h0);
        checkOutput("reset_irq", {31'h0, o_IRQ}, 32'h0);
        i_Rst = 1'b0;
        idle(8);

        // Single frame, including stop-sample to not_empty and not_empty to IRQ latency.
        sendFrame(8'hA5, 1'b1);
        @(negedge i_Clk);
        expectReg("a5_before_push", A_STATUS, 32'h0);
        @(negedge i_Clk);
        expectReg("a5_status", A_STATUS, 32'h0101);
        checkOutput("a5_irq_lag", {31'h0, o_IRQ}, 32'h0);
        @(negedge i_Clk);
        checkOutput("a5_irq", {31'h0, o_IRQ}, IRQ_ON);
        expectReg("a5_data", A_DATA, 32'h0000_00A5);
        expectReg("decode_chunk3", 16'h00C0, 32'h0);
        expectReg("decode_chunk0", 16'h0001, 32'h0);
        expectReg("unused_off", A_UNUSED, 32'h0);
        applyStimulus(A_DATA, 4'h1, 32'h0);
        expectReg("a5_popped", A_STATUS, 32'h0);
        @(negedge i_Clk);
        checkOutput("a5_irq_clear", {31'h0, o_IRQ}, 32'h0);

        // Overflow: five frames into a four-entry FIFO.
        idle(4);
        for (int i = 1; i <= 5; i++) begin
            sendFrame(8'(i), 1'b1);
            idle(4);
        end
        expectReg("ovf_status", A_STATUS, 32'h0407);
        checkOutput("ovf_irq", {31'h0, o_IRQ}, IRQ_ON);
        for (int i = 1; i <= 4; i++) popExpect($sformatf("ovf_data%0d", i), 8'(i));
        expectReg("ovf_drained", A_STATUS, 32'h0004);
        applyStimulus(A_CTRL, 4'h2, 32'h4);
        expectReg("ovf_clr_no_be0", A_STATUS, 32'h0004);
        applyStimulus(A_CTRL, 4'h1, 32'h4);
        expectReg("ovf_cleared", A_STATUS, 32'h0);

        // Framing error, then a good frame once the line has idled.
        sendFrame(8'h3C, 1'b0);
        idle(4);
        expectReg("ferr_status", A_STATUS, 32'h0008);
        expectReg("ctrl_reads_0", A_CTRL, 32'h0);
        sendFrame(8'h55, 1'b1);
        idle(4);
        expectReg("ferr_next_status", A_STATUS, 32'h0109);
        popExpect("ferr_next_data", 8'h55);
        applyStimulus(A_CTRL, 4'h1, 32'h8);
        expectReg("ferr_cleared", A_STATUS, 32'h0);

        // One-clock glitch must not start a frame; a real frame afterwards still works.
        idle(4);
        i_UART_RX = 1'b0;
        @(negedge i_Clk);
        idle(12);
        expectReg("glitch_status", A_STATUS, 32'h0);
        sendFrame(8'h5A, 1'b1);
        idle(4);
        expectReg("post_glitch", A_STATUS, 32'h0101);
        expectReg("post_glitch_data", A_DATA, 32'h0000_005A);

        // Fill to four, then pop in the same cycle the fifth byte is pushed.
        for (int i = 0; i < 3; i++) begin
            sendFrame(8'h11 + 8'(i), 1'b1);
            idle(4);
        end
        expectReg("pp_full", A_STATUS, 32'h0403);
        sendFrame(8'h14, 1'b1);
        @(negedge i_Clk);
        applyStimulus(A_DATA, 4'h1, 32'h0);
        idle(4);
        expectReg("pp_status", A_STATUS, 32'h0403);
        for (int i = 0; i < 4; i++) popExpect($sformatf("pp_data%0d", i), 8'h11 + 8'(i));
        expectReg("pp_empty", A_STATUS, 32'h0);

        // Reset during data bit 3, with a byte already queued.
        sendFrame(8'h77, 1'b1);
        idle(4);
        partial = 8'h96;
        sendBit(1'b0);
        for (int i = 0; i < 3; i++) sendBit(partial[i]);
        i_UART_RX = partial[3];
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b1;
        expectReg("rst_status", A_STATUS, 32'h0);
        expectReg("rst_data", A_DATA, 32'h0);
        checkOutput("rst_irq", {31'h0, o_IRQ}, 32'h0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (48) @(negedge i_Clk);
        expectReg("held_low_ignored", A_STATUS, 32'h0);
        idle(8);
        sendFrame(8'hC3, 1'b1);
        idle(4);
        expectReg("rst_next_status", A_STATUS, 32'h0101);
        popExpect("rst_next_data", 8'hC3);
        expectReg("final_empty", A_STATUS, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
